// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Resolves load-use stalls, branch flushes and cache-miss stalls with a fixed
// priority (dmiss > branch > load-use > imiss), produces E-stage operand
// forwarding selects, and tracks the stall condition in a small FSM.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   valid_d, valid_e               D / E stage valid bits
//   RS1_d, RS2_d, RS1_e, RS2_e     source registers in D and E
//   Rd_e, Rd_m, Rd_w               destination registers in E, M, W
//   RegWrite_e/_m/_w               write-back enables per stage
//   ResultSrc_e                    E result select (01 = load)
//   PCSrc_e                        taken branch / jump resolved in E
//   imiss, dmiss                   I-cache fetch / D-cache access pending
//   pc_en, en_fd, en_de, en_em     advance enables (0 = hold)
//   flush_fd_n .. flush_mw_n       active-low bubble inserts
//   ForwardA_e, ForwardB_e         00 regfile, 10 M result, 01 W result
//   stall_state                    00 RUN, 01 ISTALL, 10 DSTALL
//   stall_cycles, flush_count      performance counters
//
// Build option: define HAZARD_PERF_CNT_EN to implement the saturating
// performance counters; otherwise both read as constant zero.

module hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned SRC_WIDTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_d,
  input  logic                      valid_e,
  input  logic [REG_ADDR_WIDTH-1:0] RS1_d,
  input  logic [REG_ADDR_WIDTH-1:0] RS2_d,
  input  logic [REG_ADDR_WIDTH-1:0] RS1_e,
  input  logic [REG_ADDR_WIDTH-1:0] RS2_e,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_e,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_m,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_w,
  input  logic                      RegWrite_e,
  input  logic                      RegWrite_m,
  input  logic                      RegWrite_w,
  input  logic [SRC_WIDTH-1:0]      ResultSrc_e,
  input  logic                      PCSrc_e,
  input  logic                      imiss,
  input  logic                      dmiss,
  output logic                      pc_en,
  output logic                      en_fd,
  output logic                      en_de,
  output logic                      en_em,
  output logic                      flush_fd_n,
  output logic                      flush_de_n,
  output logic                      flush_em_n,
  output logic                      flush_mw_n,
  output logic [1:0]                ForwardA_e,
  output logic [1:0]                ForwardB_e,
  output logic [1:0]                stall_state,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               flush_count
);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StIStall = 2'b01,
    StDStall = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic lu, br;

  assign lu = valid_d && valid_e && RegWrite_e && (ResultSrc_e == SRC_WIDTH'(1)) &&
              (Rd_e != '0) && ((Rd_e == RS1_d) || (Rd_e == RS2_d));
  assign br = valid_e && PCSrc_e;

  // Stall / flush decode, strict priority dmiss > br > lu > imiss.
  always_comb begin
    pc_en      = 1'b1;
    en_fd      = 1'b1;
    en_de      = 1'b1;
    en_em      = 1'b1;
    flush_fd_n = 1'b1;
    flush_de_n = 1'b1;
    flush_em_n = 1'b1;
    flush_mw_n = 1'b1;
    if (!rst_n) begin
      pc_en      = 1'b0;
      en_fd      = 1'b0;
      en_de      = 1'b0;
      en_em      = 1'b0;
      flush_fd_n = 1'b0;
      flush_de_n = 1'b0;
      flush_em_n = 1'b0;
      flush_mw_n = 1'b0;
    end else if (dmiss) begin
      pc_en      = 1'b0;
      en_fd      = 1'b0;
      en_de      = 1'b0;
      en_em      = 1'b0;
      flush_mw_n = 1'b0;
    end else if (br && imiss) begin
      // Park the branch in E until the redirected fetch can be issued.
      pc_en      = 1'b0;
      en_fd      = 1'b0;
      en_de      = 1'b0;
      flush_em_n = 1'b0;
    end else if (br) begin
      flush_fd_n = 1'b0;
      flush_de_n = 1'b0;
    end else if (lu) begin
      pc_en      = 1'b0;
      en_fd      = 1'b0;
      flush_de_n = 1'b0;
    end else if (imiss) begin
      pc_en      = 1'b0;
      flush_fd_n = 1'b0;
    end
  end

  // Operand forwarding; the younger M result wins over W.
  always_comb begin
    ForwardA_e = 2'b00;
    ForwardB_e = 2'b00;
    if (rst_n) begin
      if (RegWrite_m && (Rd_m != '0) && (Rd_m == RS1_e)) begin
        ForwardA_e = 2'b10;
      end else if (RegWrite_w && (Rd_w != '0) && (Rd_w == RS1_e)) begin
        ForwardA_e = 2'b01;
      end
      if (RegWrite_m && (Rd_m != '0) && (Rd_m == RS2_e)) begin
        ForwardB_e = 2'b10;
      end else if (RegWrite_w && (Rd_w != '0) && (Rd_w == RS2_e)) begin
        ForwardB_e = 2'b01;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (dmiss) begin
          state_d = StDStall;
        end else if (imiss) begin
          state_d = StIStall;
        end
      end
      StIStall: begin
        if (dmiss) begin
          state_d = StDStall;
        end else if (!imiss) begin
          state_d = StRun;
        end
      end
      StDStall: begin
        if (!dmiss) begin
          state_d = imiss ? StIStall : StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Gated so the state reads RUN for the whole reset window, not just after the edge.
  assign stall_state = rst_n ? state_q : StRun;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        br_flush;

  // Only the branch path (not the imiss path) counts as a flush event.
  assign br_flush = br && !dmiss && !imiss;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (br_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = rst_n ? stall_cnt_q : '0;
  assign flush_count  = rst_n ? flush_cnt_q : '0;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, SHALL set register-address width.
REQ-002 Parameter SRC_WIDTH, default 2, SHALL set ResultSrc width.
REQ-003 clk  in  1  SHALL be the clock; all state updates on rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 valid_d, valid_e  in  1 each  SHALL be the valid bits of the D and E stages.
REQ-006 RS1_d, RS2_d / RS1_e, RS2_e  in  REG_ADDR_WIDTH  SHALL be the source registers in D and in E.
REQ-007 Rd_e, Rd_m, Rd_w  in  REG_ADDR_WIDTH  SHALL be the destination registers in E, M and W.
REQ-008 RegWrite_e, RegWrite_m, RegWrite_w  in  1  SHALL be the write-back enables per stage.
REQ-009 ResultSrc_e  in  SRC_WIDTH  SHALL be the E result select; 2'b01 marks a load.
REQ-010 PCSrc_e  in  1  SHALL indicate a taken branch or jump resolved in E.
REQ-011 imiss, dmiss  in  1  SHALL be level signals, high while the I-cache fetch or M-stage D-cache access is incomplete.
REQ-012 pc_en, en_fd, en_de, en_em  out  1  SHALL be the advance enables for the PC, F/D, D/E and E/M registers (low = hold).
REQ-013 flush_fd_n, flush_de_n, flush_em_n, flush_mw_n  out  1  SHALL be active-low bubble inserts; a flush overrides the matching enable.
REQ-014 ForwardA_e, ForwardB_e  out  2  SHALL be the E operand selects: 00 register file, 10 M result, 01 W result.
REQ-015 stall_state  out  2  SHALL expose the FSM state: 00 RUN, 01 ISTALL, 10 DSTALL.
REQ-016 stall_cycles, flush_count  out  32  SHALL be the performance counters (see Configuration).

Function
REQ-017 Default outputs SHALL be all enables 1, all flushes 1 and forwards 00.
REQ-018 Load-use (lu) SHALL be valid_d & valid_e & RegWrite_e & ResultSrc_e==01 & Rd_e!=0 & (Rd_e==RS1_d | Rd_e==RS2_d).
REQ-019 Branch (br) SHALL be valid_e & PCSrc_e.
REQ-020 Output priority SHALL be dmiss > br > lu > imiss, evaluated combinationally in the same cycle.
REQ-021 dmiss: pc_en, en_fd, en_de and en_em SHALL be 0, flush_mw_n 0, all other flushes 1.
REQ-022 br without imiss: flush_fd_n and flush_de_n SHALL be 0, pc_en 1.
REQ-023 br with imiss: pc_en, en_fd and en_de SHALL be 0, flush_em_n 0, so the branch is held in E until the fetch completes.
REQ-024 lu: pc_en and en_fd SHALL be 0 and flush_de_n 0; this also covers lu with imiss.
REQ-025 imiss alone: pc_en SHALL be 0 and flush_fd_n 0; downstream stages advance.
REQ-026 ForwardA_e SHALL be 10 if RegWrite_m & Rd_m!=0 & Rd_m==RS1_e, else 01 if RegWrite_w & Rd_w!=0 & Rd_w==RS1_e, else 00; ForwardB_e SHALL follow the same rule on RS2_e; M beats W.
REQ-027 FSM from RUN: dmiss -> DSTALL; else imiss -> ISTALL.
REQ-028 FSM from ISTALL: dmiss -> DSTALL; else !imiss -> RUN.
REQ-029 FSM from DSTALL: hold while dmiss; else imiss -> ISTALL; else RUN.
REQ-030 The FSM state SHALL NOT alter outputs except through stall_state and the counters.

Reset
REQ-031 While rst_n=0, all flushes and enables SHALL be 0, forwards 00, the FSM SHALL be RUN and the counters 0.
REQ-032 Reset asserted mid-stall SHALL abandon the stall, and the block SHALL be in RUN on the first cycle after release.

Configuration
REQ-033 With HAZARD_PERF_CNT_EN defined, stall_cycles SHALL increment on each non-reset cycle with pc_en=0, and flush_count SHALL increment on each cycle with flush_fd_n=0 caused by br; both SHALL saturate at 0xFFFFFFFF.
REQ-034 Without HAZARD_PERF_CNT_EN, both counters SHALL be constant 0 and contain no flops.

Verification
REQ-035 Load x5 in E, RS1_d=5, valid both -> pc_en=0, en_fd=0, flush_de_n=0 for one cycle, then ForwardA_e=01 once the load reaches W.
REQ-036 PCSrc_e=1, valid_e=1, imiss=0 -> flush_fd_n=0, flush_de_n=0, pc_en=1; flush_count +1.
REQ-037 imiss high 3 cycles with a branch in E -> en_de=0, flush_em_n=0 for 3 cycles, stall_state=01; branch flush on the cycle after imiss falls.
REQ-038 dmiss and imiss both raised, dmiss drops after 4 cycles, imiss after 6 -> stall_state 10 for 4 cycles, 01 for 2 cycles, then 00; stall_cycles=6.
REQ-039 Rd_m=Rd_w=7, both RegWrite, RS2_e=7 -> ForwardB_e=10; Rd_m=0 -> 01.
REQ-040 rst_n low during DSTALL -> all outputs at reset values next cycle, stall_state=00 after release.
